// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, shift-op and flag-index constants for alu_pipe
//
// Purpose: shared encodings for the pipelined ALU and its barrel shifter.
// Ports: none (package).

package alu_pkg;

    // Arithmetic ops (Sel[2] = 1)
    localparam logic [1:0] OP_TRA  = 2'b00;
    localparam logic [1:0] OP_ADDC = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_TRB  = 2'b11;

    // Logic ops (Sel[2] = 0)
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    // Shift ops (Sel[4:3])
    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ZERO = 2'b11;

    // Bit positions inside flags = {C, V, N, Z}
    localparam int F_C = 3;
    localparam int F_V = 2;
    localparam int F_N = 1;
    localparam int F_Z = 0;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational barrel shifter for the alu_pipe output stage
//
// Purpose: pass / logical left / logical right / zero, variable distance.
// Ports:
//   data_i  WIDTH  value to shift
//   op_i    2      shift op (SH_*)
//   amt_i   SHW    shift distance
//   data_o  WIDTH  shifted value

module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic [SHW-1:0]   amt_i,
    output logic [WIDTH-1:0] data_o
);

    // Only reachable when WIDTH is not a power of two; such distances give 0.
    logic amt_oor;
    assign amt_oor = (32'(amt_i) >= WIDTH);

    always_comb begin
        data_o = '0;
        case (op_i)
            SH_PASS: data_o = data_i;
            SH_LSL:  if (!amt_oor) data_o = data_i << amt_i;
            SH_LSR:  if (!amt_oor) data_o = data_i >> amt_i;
            SH_ZERO: data_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined ALU with valid/ready handshake and status flags
//
// Purpose: stage 1 computes arith/logic result with carry/overflow, stage 2
// applies the shift and derives N/Z. 2-cycle latency, 1 op/cycle throughput.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   A, B                operands (WIDTH)
//   Sel                 [4:3] shift op, [2] arith/logic, [1:0] op
//   CarryIn, carry_sel  AddC carry source (external or internal c_reg)
//   sh_amt              shift distance (SHW)
//   out_valid/out_ready output handshake
//   Y, flags            result and {C, V, N, Z}

module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Sel,
    input  logic             CarryIn,
    input  logic             carry_sel,
    input  logic [SHW-1:0]   sh_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic [3:0]       flags
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_r_q;
    logic             s1_c_q;
    logic             s1_v_q;
    logic [1:0]       s1_sh_op_q;
    logic [SHW-1:0]   s1_amt_q;
    logic             c_reg_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic [3:0]       flags_q;

    logic             s2_ready;
    logic             accept;
    logic             s1_adv;

    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign accept   = in_valid && in_ready;
    assign s1_adv   = s1_valid_q && s2_ready;

    // Stage 1: arith/logic with one extra bit to catch the carry out.
    logic [WIDTH:0] a_x, b_x, r_d;
    logic           cin;
    logic           is_add;
    logic           c1_d, v1_d;

    assign a_x = {1'b0, A};
    assign b_x = {1'b0, B};
    assign cin = carry_sel ? c_reg_q : CarryIn;

    always_comb begin
        r_d = '0;
        if (Sel[2]) begin
            case (Sel[1:0])
                OP_TRA:  r_d = a_x;
                OP_ADDC: r_d = a_x + b_x + {{WIDTH{1'b0}}, cin};
                OP_ADD:  r_d = a_x + b_x;
                OP_TRB:  r_d = b_x;
            endcase
        end else begin
            case (Sel[1:0])
                OP_AND:  r_d = {1'b0, A & B};
                OP_OR:   r_d = {1'b0, A | B};
                OP_XOR:  r_d = {1'b0, A ^ B};
                OP_NOTA: r_d = {1'b0, ~A};
            endcase
        end
    end

    assign is_add = Sel[2] && (Sel[1:0] == OP_ADDC || Sel[1:0] == OP_ADD);
    assign c1_d   = is_add && r_d[WIDTH];
    // Signed overflow: both operands share a sign the result does not.
    assign v1_d   = is_add && (A[WIDTH-1] == B[WIDTH-1]) && (r_d[WIDTH-1] != A[WIDTH-1]);

    // Stage 2: shift, then derive N/Z from the shifted value.
    logic [WIDTH-1:0] y_d;
    logic [3:0]       flags_d;

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data_i (s1_r_q),
        .op_i   (s1_sh_op_q),
        .amt_i  (s1_amt_q),
        .data_o (y_d)
    );

    always_comb begin
        flags_d      = '0;
        flags_d[F_C] = s1_c_q;
        flags_d[F_V] = s1_v_q;
        flags_d[F_N] = y_d[WIDTH-1];
        flags_d[F_Z] = (y_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            s1_c_q      <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_sh_op_q  <= '0;
            s1_amt_q    <= '0;
            c_reg_q     <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= '0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_r_q     <= r_d[WIDTH-1:0];
                s1_c_q     <= c1_d;
                s1_v_q     <= v1_d;
                s1_sh_op_q <= Sel[4:3];
                s1_amt_q   <= sh_amt;
                // Updated at stage 1 so a chained AddC on the next cycle sees it.
                if (is_add) c_reg_q <= c1_d;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                out_valid_q <= 1'b1;
                y_q         <= y_d;
                flags_q     <= flags_d;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Y         = y_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe (WIDTH=8 and WIDTH=16)

module tb_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  f;
        logic        c;
        logic        add;
    } exp_t;

    // WIDTH=8 instance
    logic       rst, in_valid, in_ready, CarryIn, carry_sel, out_valid, out_ready;
    logic [7:0] A, B, Y;
    logic [4:0] Sel;
    logic [2:0] sh_amt;
    logic [3:0] flags;

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Sel(Sel), .CarryIn(CarryIn), .carry_sel(carry_sel),
        .sh_amt(sh_amt), .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .flags(flags)
    );

    // WIDTH=16 instance
    logic        in_valid16, in_ready16, CarryIn16, carry_sel16, out_valid16, out_ready16;
    logic [15:0] A16, B16, Y16;
    logic [4:0]  Sel16;
    logic [3:0]  sh16;
    logic [3:0]  flags16;

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(A16), .B(B16), .Sel(Sel16), .CarryIn(CarryIn16), .carry_sel(carry_sel16),
        .sh_amt(sh16), .out_valid(out_valid16), .out_ready(out_ready16),
        .Y(Y16), .flags(flags16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on a w-bit datapath.
    function automatic exp_t model(int w, int unsigned a, int unsigned b, int unsigned sel,
                                   int unsigned cin, int unsigned amt);
        exp_t e;
        int unsigned mask, full, r, y, op, shop, sa, sb, sr;
        bit arith, v;
        mask  = (32'd1 << w) - 1;
        arith = ((sel >> 2) & 1) == 1;
        op    = sel & 3;
        shop  = (sel >> 3) & 3;
        if (arith) begin
            case (op)
                0: full = a;
                1: full = a + b + cin;
                2: full = a + b;
                default: full = b;
            endcase
        end else begin
            case (op)
                0: full = a & b;
                1: full = a | b;
                2: full = a ^ b;
                default: full = ~a & mask;
            endcase
        end
        r     = full & mask;
        e.add = arith && (op == 1 || op == 2);
        sa    = (a >> (w - 1)) & 1;
        sb    = (b >> (w - 1)) & 1;
        sr    = (r >> (w - 1)) & 1;
        e.c   = e.add && (((full >> w) & 1) == 1);
        v     = e.add && (sa == sb) && (sr != sa);
        case (shop)
            0: y = r;
            1: y = (amt >= w) ? 0 : ((r << amt) & mask);
            2: y = (amt >= w) ? 0 : (r >> amt);
            default: y = 0;
        endcase
        e.y = y[15:0];
        e.f = {e.c, v, ((y >> (w - 1)) & 1) == 1, y == 0};
        return e;
    endfunction

    // Scoreboard for the WIDTH=8 instance
    exp_t        q8[$];
    exp_t        mon_e;
    int unsigned mc8 = 0;
    int          nres8 = 0;

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            mc8 = 0;
        end else begin
            if (out_valid) begin
                if (q8.size() == 0) begin
                    chk("out_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("Y", {24'd0, Y}, {16'd0, q8[0].y});
                    chk("flags", {28'd0, flags}, {28'd0, q8[0].f});
                    if (out_ready) begin
                        void'(q8.pop_front());
                        nres8++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                mon_e = model(8, A, B, Sel, carry_sel ? mc8 : {31'd0, CarryIn}, sh_amt);
                if (mon_e.add) mc8 = {31'd0, mon_e.c};
                q8.push_back(mon_e);
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [4:0] s,
                         input logic ci, input logic cs, input logic [2:0] amt);
        int n;
        n = 0;
        A = a; B = b; Sel = s; CarryIn = ci; carry_sel = cs; sh_amt = amt;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send8_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait8(output logic [7:0] y, output logic [3:0] f, output int lat);
        int n;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("wait8_timeout", 32'd0, 32'd1);
        y   = Y;
        f   = flags;
        lat = n;
        @(posedge clk);
        #1;
    endtask

    task automatic run16(input string nm, input logic [15:0] a, input logic [4:0] s,
                         input logic [3:0] amt, input logic [15:0] ey, input logic [3:0] ef);
        exp_t e;
        int   n;
        n = 0;
        @(posedge clk);
        #1;
        A16 = a; B16 = 16'h1234; Sel16 = s; sh16 = amt; in_valid16 = 1'b1;
        @(negedge clk);
        chk({nm, "_rdy"}, {31'd0, in_ready16}, 32'd1);
        @(posedge clk);
        #1 in_valid16 = 1'b0;
        @(negedge clk);
        while (!out_valid16 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, {31'd0, out_valid16}, 32'd1);
        chk({nm, "_y"}, {16'd0, Y16}, {16'd0, ey});
        chk({nm, "_flags"}, {28'd0, flags16}, {28'd0, ef});
        e = model(16, a, 16'h1234, s, 0, amt);
        chk({nm, "_model_y"}, {16'd0, Y16}, {16'd0, e.y});
        chk({nm, "_model_f"}, {28'd0, flags16}, {28'd0, e.f});
    endtask

    logic [7:0] ry, y_hold;
    logic [3:0] rf;
    int         lat, idx, n, base;
    logic       took;
    logic [7:0] opa[4], opb[4];
    logic [4:0] ops[4];
    exp_t       pe;

    initial begin
        rst = 1'b1; in_valid = 1'b1; A = 8'h55; B = 8'h0F; Sel = 5'b00110;
        CarryIn = 1'b1; carry_sel = 1'b0; sh_amt = 3'd0; out_ready = 1'b1;
        in_valid16 = 1'b0; A16 = '0; B16 = '0; Sel16 = '0; CarryIn16 = 1'b0;
        carry_sel16 = 1'b0; sh16 = '0; out_ready16 = 1'b1;

        // Pin the reference model with hand-computed values
        pe = model(8, 'hF0, 'h20, 'b00110, 0, 0);
        chk("pin_add", {20'd0, pe.f, pe.y[7:0]}, 32'h810);
        pe = model(8, 'h7F, 'h01, 'b00110, 0, 0);
        chk("pin_ovf", {20'd0, pe.f, pe.y[7:0]}, 32'h680);
        pe = model(16, 'h0001, 0, 'b01100, 0, 15);
        chk("pin_lsl16", {12'd0, pe.f, pe.y}, 32'h28000);

        // Reset held with in_valid asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_Y", {24'd0, Y}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_accept", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Add with carry out, and latency from presentation
        send8(8'hF0, 8'h20, 5'b00110, 1'b0, 1'b0, 3'd0);
        wait8(ry, rf, lat);
        chk("add_latency", lat, 32'd2);
        chk("add_y", {24'd0, ry}, 32'h10);
        chk("add_flags", {28'd0, rf}, 32'h8);

        // Add chain: AddC on the next cycle picks up the internal carry
        send8(8'hFF, 8'h01, 5'b00110, 1'b0, 1'b0, 3'd0);
        send8(8'h00, 8'h00, 5'b00101, 1'b0, 1'b1, 3'd0);
        wait8(ry, rf, lat);
        chk("chain1_y", {24'd0, ry}, 32'h00);
        chk("chain1_flags", {28'd0, rf}, 32'h9);
        wait8(ry, rf, lat);
        chk("chain2_y", {24'd0, ry}, 32'h01);
        chk("chain2_flags", {28'd0, rf}, 32'h0);

        // Signed overflow
        send8(8'h7F, 8'h01, 5'b00110, 1'b0, 1'b0, 3'd0);
        wait8(ry, rf, lat);
        chk("ovf_y", {24'd0, ry}, 32'h80);
        chk("ovf_flags", {28'd0, rf}, 32'h6);

        // XOR then logical right shift by 4
        send8(8'hF0, 8'h0F, 5'b10010, 1'b0, 1'b0, 3'd4);
        wait8(ry, rf, lat);
        chk("xor_lsr_y", {24'd0, ry}, 32'h0F);
        chk("xor_lsr_flags", {28'd0, rf}, 32'h0);

        // WIDTH=16 shifts at the top distance
        run16("lsl15", 16'h0001, 5'b01100, 4'd15, 16'h8000, 4'h2);
        run16("zero",  16'h0001, 5'b11100, 4'd15, 16'h0000, 4'h1);

        // Backpressure: 4 ops with out_ready low
        for (int i = 0; i < 4; i++) begin
            opa[i] = 8'($urandom);
            opb[i] = 8'($urandom);
            ops[i] = 5'($urandom);
        end
        base = nres8;
        @(posedge clk);
        #1;
        out_ready = 1'b0; idx = 0; carry_sel = 1'b0; sh_amt = 3'd1;
        for (int c = 0; c < 3; c++) begin
            A = opa[idx]; B = opb[idx]; Sel = ops[idx]; in_valid = 1'b1;
            @(negedge clk);
            took = in_ready;
            if (c == 2) begin
                chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                y_hold = Y;
            end
            @(posedge clk);
            #1;
            if (took) idx++;
        end
        chk("bp_accepts", idx, 32'd2);
        @(negedge clk);
        chk("bp_y_stable", {24'd0, Y}, {24'd0, y_hold});
        chk("bp_in_ready_held", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        n = 0;
        while (idx < 4 && n < 20) begin
            A = opa[idx]; B = opb[idx]; Sel = ops[idx]; in_valid = 1'b1;
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) idx++;
            n++;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_results", nres8 - base, 32'd4);
        chk("bp_queue_empty", q8.size(), 32'd0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = 8'($urandom);
            B         = 8'($urandom);
            Sel       = 5'($urandom);
            CarryIn   = 1'($urandom);
            carry_sel = 1'($urandom);
            sh_amt    = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rand_drained", q8.size(), 32'd0);
        chk("rand_out_idle", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
